multicycle_alu: RTL and testbench

//  Execution-side consumer of the 4-bit alu_op code produced by the ALU control decoder.

---
 rtl/multicycle_alu.sv | 141 ++++++++++++++
 tb/tb_multicycle_alu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU back-end behind the alu_op decoder.
// Operands are captured on a valid/ready handshake. Most ops finish in one cycle.
// SLL/SRL shift iteratively, and the result is held until the consumer takes it.
// Optional build macro MC_ALU_FAST_SHIFT_EN: shift up to 4 bits per edge instead of 1.
module multicycle_alu #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic                  is_branch,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  bcond,
  output logic                  illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

`ifdef MC_ALU_FAST_SHIFT_EN
  localparam logic [SHAMT_WIDTH-1:0] STEP_MAX = SHAMT_WIDTH'(4);
`else
  localparam logic [SHAMT_WIDTH-1:0] STEP_MAX = SHAMT_WIDTH'(1);
`endif

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_bcond;
  logic                    r_illegal;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic                    r_srl;

  logic                    w_accept;
  logic                    w_is_shift;
  logic [SHAMT_WIDTH-1:0]  w_cnt_src;
  logic [SHAMT_WIDTH-1:0]  w_step;
  logic [SHAMT_WIDTH-1:0]  w_cnt_rem;
  logic [DATA_WIDTH-1:0]   w_shift_src;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic                    w_dir_srl;
  logic [DATA_WIDTH-1:0]   w_diff;
  logic [DATA_WIDTH-1:0]   w_alu_res;
  logic                    w_alu_bc;
  logic                    w_alu_ill;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign result     = r_result;
  assign bcond      = r_bcond;
  assign illegal_op = r_illegal;

  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = !is_branch && (alu_op[3:1] == 3'b101);
  assign w_diff     = op_a - op_b;

  // One shifter serves both the accept edge (fresh operands) and the SHIFT state
  // (held value). The accept edge already performs the first step, which keeps the
  // accept-to-out_valid latency at max(1,n) instead of n+1.
  assign w_cnt_src   = (r_state == S_IDLE) ? op_b[SHAMT_WIDTH-1:0] : r_cnt;
  assign w_shift_src = (r_state == S_IDLE) ? op_a : r_result;
  assign w_dir_srl   = (r_state == S_IDLE) ? alu_op[0] : r_srl;
  assign w_step      = (w_cnt_src > STEP_MAX) ? STEP_MAX : w_cnt_src;
  assign w_cnt_rem   = w_cnt_src - w_step;
  assign w_shifted   = w_dir_srl ? (w_shift_src >> w_step) : (w_shift_src << w_step);

  // Decode the captured op into result / branch condition / illegal flag
  always_comb begin
    w_alu_res = '0;
    w_alu_bc  = 1'b0;
    w_alu_ill = 1'b0;
    if (is_branch) begin
      w_alu_res = w_diff;
      case (alu_op)
        4'b0000: w_alu_bc = (op_a == op_b);
        4'b1010: w_alu_bc = (op_a != op_b);
        4'b1000: w_alu_bc = ($signed(op_a) <  $signed(op_b));
        4'b1011: w_alu_bc = ($signed(op_a) >= $signed(op_b));
        default: begin
          w_alu_res = '0;
          w_alu_ill = 1'b1;
        end
      endcase
    end else begin
      case (alu_op)
        4'b0000: w_alu_res = op_a + op_b;
        4'b0001: w_alu_res = w_diff;
        4'b0100: w_alu_res = op_a & op_b;
        4'b0101: w_alu_res = op_a | op_b;
        4'b1000: w_alu_res = op_a ^ op_b;
        4'b1010,
        4'b1011: w_alu_res = w_shifted;
        default: w_alu_ill = 1'b1;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = (w_is_shift && (w_cnt_rem != '0)) ? S_SHIFT : S_DONE;
      S_SHIFT: if (w_cnt_rem == '0) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate while shifting, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result  <= '0;
      r_bcond   <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_srl     <= 1'b0;
    end else if (w_accept) begin
      r_result  <= w_alu_res;
      r_bcond   <= w_alu_bc;
      r_illegal <= w_alu_ill;
      r_cnt     <= w_cnt_rem;
      r_srl     <= alu_op[0];
    end else if (r_state == S_SHIFT) begin
      r_result  <= w_shifted;
      r_cnt     <= w_cnt_rem;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu with an expected-result queue.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic        is_branch;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        bcond;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        bc;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .is_branch(is_branch), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .bcond(bcond), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic int shift_lat(input int n);
`ifdef MC_ALU_FAST_SHIFT_EN
    return (n == 0) ? 1 : (n + 3) / 4;
`else
    return (n == 0) ? 1 : n;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for its result, compare against the queue head, then drain.
  task automatic do_op(input string tag, input logic [3:0] op, input logic br,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eb, input logic ei,
                       input int el, input int hold);
    exp_t e;
    int   lat;
    int   w;
    logic busy_ok;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    chk({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
    sb.push_back('{er, eb, ei, el});
    @(negedge clk);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    alu_op    = op;
    is_branch = br;
    op_a      = a;
    op_b      = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    op_a      = ~a;
    op_b      = ~b;
    alu_op    = 4'b0011;
    is_branch = ~br;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, ":busy"},    {31'd0, busy_ok}, 32'd1);
    chk({tag, ":latency"}, lat, e.lat);
    chk({tag, ":result"},  result, e.res);
    chk({tag, ":bcond"},   {31'd0, bcond}, {31'd0, e.bc});
    chk({tag, ":illegal"}, {31'd0, illegal_op}, {31'd0, e.ill});
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk({tag, ":held_valid"},  {31'd0, out_valid}, 32'd1);
      chk({tag, ":held_result"}, result, e.res);
      chk({tag, ":held_ready"},  {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ":drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ":drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 4'b0000;
    is_branch = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst:out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst:result",    result, 32'd0);
    chk("rst:bcond",     {31'd0, bcond}, 32'd0);
    chk("rst:illegal",   {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op("add_wrap", 4'b0000, 1'b0, 32'd7, 32'hFFFF_FFFF, 32'd6, 1'b0, 1'b0, 1, 0);
    do_op("sll31",    4'b1010, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, shift_lat(31), 0);
    do_op("blt",      4'b1000, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1, 0);
    do_op("bge",      4'b1011, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 0);
    do_op("beq",      4'b0000, 1'b1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1, 0);
    do_op("bne",      4'b1010, 1'b1, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1, 0);
    do_op("br_ill",   4'b0001, 1'b1, 32'd9, 32'd4, 32'd0, 1'b0, 1'b1, 1, 0);
    do_op("xor_bp",   4'b1000, 1'b0, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b0, 1, 5);

    // Reset in the middle of a long SRL: in-flight op is discarded
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'b1011; is_branch = 1'b0;
    op_a = 32'h8000_0000; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst:out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst:in_ready",  {31'd0, in_ready}, 32'd1);
    chk("midrst:result",    result, 32'd0);
    chk("midrst:illegal",   {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op("add_post", 4'b0000, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);
    do_op("ill_0011", 4'b0011, 1'b0, 32'd12, 32'd34, 32'd0, 1'b0, 1'b1, 1, 0);
    do_op("srl_sh0",  4'b1011, 1'b0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1, 0);
    do_op("srl20",    4'b1011, 1'b0, 32'h8000_0000, 32'd20, 32'h0000_0800, 1'b0, 1'b0, shift_lat(20), 0);
    do_op("sll_hi",   4'b1010, 1'b0, 32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, shift_lat(1), 0);
    do_op("srl5",     4'b1011, 1'b0, 32'hF000_0000, 32'd5, 32'h0780_0000, 1'b0, 1'b0, shift_lat(5), 0);
    do_op("sub_neg",  4'b0001, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 0);
    do_op("and",      4'b0100, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1, 0);
    do_op("or",       4'b0101, 1'b0, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 1'b0, 1, 2);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op("rnd_add", 4'b0000, 1'b0, ra, rb, ra + rb, 1'b0, 1'b0, 1, 0);
      do_op("rnd_xor", 4'b1000, 1'b0, ra, rb, ra ^ rb, 1'b0, 1'b0, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
